// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types and constants for the FIFO burst scheduler
package fifo_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  localparam int BUF_DEPTH = 3;

  // Wide enough for any supported data width; the top slices WIDTH/8 bits.
  localparam int STRB_MAX_W = 128;
  localparam logic [STRB_MAX_W-1:0] STRB_ALL = '1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_out_buf.sv
// rtl/axis_out_buf.sv - 3-entry {last, data} output buffer with sync clear
module axis_out_buf
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           push,
  input  logic [WIDTH:0] push_data,
  input  logic           pop,
  output logic [WIDTH:0] head_data,
  output logic [1:0]     count
);

  logic [WIDTH:0] mem_q [BUF_DEPTH];
  logic [WIDTH:0] mem_d [BUF_DEPTH];
  logic [1:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    do_push  = push && ((count_q != 2'(BUF_DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_burst_scheduler.sv
// rtl/fifo_burst_scheduler.sv - FIFO read sequencer emitting BURST_LEN-word AXI-Stream frames
// Optional partial-frame flush after TIMEOUT idle cycles: FIFO_SCHED_TIMEOUT_FLUSH_EN
module fifo_burst_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4096,
  parameter int BURST_LEN = 1000,
  parameter int CNT_W     = $clog2(DEPTH) + 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 m00_axis_aclk,
  input  logic                 m00_axis_areset,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     fifo_rd_count,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 m00_axis_tready,
  output logic                 m00_axis_tvalid,
  output logic [WIDTH-1:0]     m00_axis_tdata,
  output logic [WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                 m00_axis_tlast,
  output logic                 burst_active,
  output logic [31:0]          frames_sent
);

  localparam int               IDX_W    = clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LEN_FULL = IDX_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(BURST_LEN);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] issued_q, issued_d;
  logic [IDX_W-1:0] sent_q, sent_d;
  logic [31:0]      frames_q, frames_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic [IDX_W-1:0] frame_len;
  logic             rd_en, accept, frame_done, start_full, out_valid;
  logic [2:0]       credits_used;
  logic [WIDTH:0]   head_data;
  logic [1:0]       buf_count;

`ifdef FIFO_SCHED_TIMEOUT_FLUSH_EN
  localparam int               TMR_W   = clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             tmr_run, flush_go;

  always_comb begin
    tmr_run  = (state_q == IDLE) && enable && !fifo_empty && (fifo_rd_count < THRESH);
    flush_go = tmr_run && (tmr_q == TMR_MAX) && (fifo_rd_count != '0);
    tmr_d    = '0;
    if (tmr_run) begin
      tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      tmr_q <= '0;
      len_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      len_q <= len_d;
    end
  end

  assign frame_len = len_q;
`else
  assign frame_len = LEN_FULL;
`endif

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    frames_d   = frames_q;
`ifdef FIFO_SCHED_TIMEOUT_FLUSH_EN
    len_d      = len_q;
`endif
    out_valid  = (buf_count != 2'd0);
    accept     = out_valid && m00_axis_tready;
    // A read still in flight owns a buffer slot, so the buffer can never overflow.
    credits_used = {1'b0, buf_count} + {2'b00, inflight_q};
    start_full = enable && (fifo_rd_count >= THRESH);
    rd_en      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_full) begin
          state_d  = BURST;
          issued_d = '0;
          sent_d   = '0;
`ifdef FIFO_SCHED_TIMEOUT_FLUSH_EN
          len_d    = LEN_FULL;
        end else if (flush_go) begin
          state_d  = BURST;
          issued_d = '0;
          sent_d   = '0;
          len_d    = IDX_W'(fifo_rd_count);
`endif
        end
      end
      BURST: begin
        rd_en      = (issued_q < frame_len) && !fifo_empty && (credits_used < 3'(BUF_DEPTH));
        frame_done = accept && (sent_q == frame_len - 1'b1);
        if (rd_en) begin
          issued_d = issued_q + 1'b1;
        end
        if (accept) begin
          sent_d = sent_q + 1'b1;
        end
        if (frame_done) begin
          state_d  = IDLE;
          frames_d = frames_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (m00_axis_areset) begin
      rd_en = 1'b0;
    end
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (issued_q == frame_len - 1'b1);
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q         <= IDLE;
      issued_q        <= '0;
      sent_q          <= '0;
      frames_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      issued_q        <= issued_d;
      sent_q          <= sent_d;
      frames_q        <= frames_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  axis_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (m00_axis_aclk),
    .clr      (m00_axis_areset),
    .push     (inflight_q),
    .push_data({inflight_last_q, fifo_dout}),
    .pop      (accept),
    .head_data(head_data),
    .count    (buf_count)
  );

  assign fifo_rd_en      = rd_en;
  assign m00_axis_tvalid = out_valid;
  assign m00_axis_tdata  = out_valid ? head_data[WIDTH-1:0] : '0;
  assign m00_axis_tlast  = out_valid && head_data[WIDTH];
  assign m00_axis_tstrb  = out_valid ? STRB_ALL[WIDTH/8-1:0] : '0;
  assign burst_active    = (state_q == BURST);
  assign frames_sent     = frames_q;

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb/tb_fifo_burst_scheduler.sv - randomized self-checking bench for fifo_burst_scheduler
module tb_fifo_burst_scheduler;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4096;
  localparam int BL      = 1000;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TIMEOUT = 1024;

  logic               clk = 1'b0;
  logic               areset = 1'b1;
  logic               enable = 1'b0;
  logic [CNT_W-1:0]   fifo_rd_count = '0;
  logic               fifo_empty = 1'b1;
  logic               fifo_rd_en;
  logic [WIDTH-1:0]   fifo_dout = '0;
  logic               tready = 1'b0;
  logic               tvalid;
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tstrb;
  logic               tlast;
  logic               burst_active;
  logic [31:0]        frames_sent;

  always #5 clk = ~clk;

  fifo_burst_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BL), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .m00_axis_aclk  (clk),
    .m00_axis_areset(areset),
    .enable         (enable),
    .fifo_rd_count  (fifo_rd_count),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .m00_axis_tready(tready),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tdata (tdata),
    .m00_axis_tstrb (tstrb),
    .m00_axis_tlast (tlast),
    .burst_active   (burst_active),
    .frames_sent    (frames_sent)
  );

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int cyc = 0;
  int beats = 0;
  int frames_model = 0;
  int beat_idx = 0;
  int outstanding = 0;
  int exp_len = BL;
  int max_gap = 0;
  int last_end_cyc = -1;
  int last_beat_cyc = 0;
  bit full_rate = 1'b1;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic update_flags();
    fifo_rd_count = CNT_W'(fifo_q.size());
    fifo_empty    = (fifo_q.size() == 0);
  endtask

  task automatic load(input int n);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    update_flags();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Ideal FIFO: a read strobe seen in a cycle yields data during the next cycle.
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      pop = fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop) begin
        chk("rd_nonempty", (fifo_q.size() > 0) ? 1 : 0, 1);
        if (fifo_q.size() > 0) begin
          fifo_dout = fifo_q.pop_front();
          outstanding++;
        end
        update_flags();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;
    int gap;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("frames_sent", frames_sent, frames_model);
      chk("tstrb", tstrb, tvalid ? 4'hF : 4'h0);
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, prev_data);
        chk("hold_last", tlast, prev_last);
      end
      if (fifo_rd_en || tvalid) chk("burst_active", burst_active, 1);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) chk("beat_expected", 0, 1);
        else chk("tdata", tdata, exp_q.pop_front());
        chk("tlast", tlast, (beat_idx == exp_len - 1) ? 1 : 0);
        if (full_rate && beat_idx > 0) chk("no_bubble", cyc - last_beat_cyc, 1);
        if (beat_idx == 0 && last_end_cyc >= 0) begin
          gap = cyc - last_end_cyc - 1;
          if (gap > max_gap) max_gap = gap;
        end
        last_beat_cyc = cyc;
        beats++;
        outstanding--;
        if (beat_idx == exp_len - 1) begin
          beat_idx = 0;
          frames_model++;
          last_end_cyc = cyc;
        end else begin
          beat_idx++;
        end
      end
      chk("buf_bound", (outstanding <= 3) ? 1 : 0, 1);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic do_reset();
    step();
    areset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_burst_active", burst_active, 0);
    chk("rst_frames_sent", frames_sent, 0);
    chk("rst_tstrb", tstrb, 0);
    chk("rst_tlast", tlast, 0);
    #1;
    fifo_q.delete();
    exp_q.delete();
    update_flags();
    frames_model = 0;
    beat_idx = 0;
    outstanding = 0;
    last_end_cyc = -1;
    areset = 1'b0;
  endtask

  task automatic quiet_window(input int n, input string name);
    int nrd;
    int nv;
    nrd = 0;
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (tvalid) nv++;
    end
    chk({name, "_rd_en"}, nrd, 0);
    chk({name, "_tvalid"}, nv, 0);
    step();
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_sent != target && n < budget) begin
      step();
      n++;
    end
    chk(name, frames_sent, target);
  endtask

  task automatic wait_beats(input int base, input int delta, input int budget, input string name);
    int n;
    n = 0;
    while (beats - base < delta && n < budget) begin
      step();
      n++;
    end
    chk(name, beats - base, delta);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int loaded;
    int n;

    // 1: sub-threshold wait, then one full frame with fixed start latency
    do_reset();
    enable = 1'b1;
    load(BL - 1);
    quiet_window(2000, "t1_wait");
    b0 = beats;
    load(1);
    @(negedge clk);
    chk("t1_lat0_active", burst_active, 0);
    chk("t1_lat0_rd", fifo_rd_en, 0);
    @(negedge clk);
    chk("t1_lat1_active", burst_active, 1);
    chk("t1_lat1_rd", fifo_rd_en, 1);
    @(negedge clk);
    chk("t1_lat2_valid", tvalid, 0);
    @(negedge clk);
    chk("t1_lat3_valid", tvalid, 1);
    step();
    wait_frames(1, 1500, "t1_frames");
    chk("t1_beats", beats - b0, BL);
    chk("t1_fifo_left", fifo_rd_count, 0);

    // 2: preloaded full FIFO, back-to-back frames
    do_reset();
    max_gap = 0;
    load(DEPTH);
    wait_frames(4, 5000, "t2_frames");
    repeat (50) step();
    chk("t2_fifo_left", fifo_rd_count, 96);
    chk("t2_frames_final", frames_sent, 4);
    chk("t2_gap_le3", (max_gap <= 3) ? 1 : 0, 1);

    // 3: random backpressure with a FIFO that trickles and runs dry mid-frame
    do_reset();
    rand_ready = 1'b1;
    full_rate = 1'b0;
    load(BL);
    loaded = BL;
    n = 0;
    while (frames_sent != 3 && n < 15000) begin
      if (loaded < 3 * BL && $urandom_range(0, 1) == 1) begin
        load(1);
        loaded++;
      end
      step();
      n++;
    end
    chk("t3_frames", frames_sent, 3);
    chk("t3_no_loss", exp_q.size(), 0);
    rand_ready = 1'b0;
    step();
    step();
    full_rate = 1'b1;

    // 4: enable gating, and enable dropped mid-frame
    do_reset();
    enable = 1'b0;
    load(2 * BL);
    quiet_window(300, "t4_disabled");
    enable = 1'b1;
    wait_frames(2, 2600, "t4_two_frames");
    b0 = beats;
    load(BL);
    wait_beats(b0, 10, 100, "t4_beat10");
    enable = 1'b0;
    wait_frames(3, 1200, "t4_completed");
    chk("t4_frame_beats", beats - b0, BL);
    load(BL);
    quiet_window(300, "t4_dropped");
    chk("t4_fifo_held", fifo_rd_count, BL);

    // 5: reset in the middle of a frame, then a clean frame
    b0 = beats;
    enable = 1'b1;
    wait_beats(b0, 500, 700, "t5_beat500");
    do_reset();
    b0 = beats;
    load(BL);
    wait_frames(1, 1500, "t5_frames");
    chk("t5_beats", beats - b0, BL);

    // 6: sub-threshold residue with the timeout flush feature
    do_reset();
    b0 = beats;
    load(10);
`ifdef FIFO_SCHED_TIMEOUT_FLUSH_EN
    exp_len = 10;
    wait_frames(1, TIMEOUT + 200, "t6_flush_frames");
    chk("t6_flush_beats", beats - b0, 10);
    exp_len = BL;
`else
    quiet_window(TIMEOUT + 200, "t6_no_flush");
    chk("t6_fifo_held", fifo_rd_count, 10);
    chk("t6_frames", frames_sent, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
